// File: rtl/settings_ctrl.sv
// Button-driven bank of saturating setting registers with MODE/UP/DOWN/RESTORE.
// Define SETTINGS_CTRL_AUTOREPEAT_EN to add hold-to-repeat on UP/DOWN.
module settings_ctrl #(
  parameter int unsigned NUM_SETTINGS  = 4,
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEFAULT_VALUE = 128,
  parameter int unsigned HOLD_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    val,
  input  logic [3:0]                    strb,
  output logic [2:0]                    sel,
  output logic [NUM_SETTINGS*WIDTH-1:0] settings,
  output logic                          changed
);

  localparam logic [WIDTH-1:0] DFLT = WIDTH'(DEFAULT_VALUE);
  localparam logic [2:0]       LAST = 3'(NUM_SETTINGS - 1);

  logic [WIDTH-1:0] regs [NUM_SETTINGS];
  logic [WIDTH-1:0] cur, nv;
  logic [3:0]       press;
  logic             mode_p, up_p, down_p, rest_p;
  logic             step_req, step_up;

  always_comb begin
    press  = strb & val;
    mode_p = press[0];
    up_p   = press[1];
    down_p = press[2];
    rest_p = press[3];
  end

  always_comb begin
    cur = '0;
    for (int unsigned k = 0; k < NUM_SETTINGS; k++)
      if (sel == 3'(k)) cur = regs[k];
  end

  // A saturated step yields nv == cur, which suppresses the changed pulse.
  always_comb begin
    if (step_up) nv = (cur == '1) ? cur : cur + WIDTH'(1);
    else         nv = (cur == '0) ? cur : cur - WIDTH'(1);
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_SETTINGS; k++)
      settings[k*WIDTH +: WIDTH] = regs[k];
  end

`ifdef SETTINGS_CTRL_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam int unsigned MAXD = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int unsigned CW   = $clog2(MAXD + 1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            dir;
  logic            held, opp, abort;

  always_comb begin
    held     = dir ? val[1] : val[2];
    opp      = dir ? down_p : up_p;
    abort    = mode_p | rest_p | ~held | opp;
    step_req = 1'b0;
    step_up  = dir;
    case (state)
      IDLE: begin
        step_req = ~mode_p & ~rest_p & (up_p ^ down_p);
        step_up  = up_p;
      end
      HOLD:    step_req = ~abort & (cnt == CW'(HOLD_DELAY - 1));
      REPEAT:  step_req = ~abort & (cnt == CW'(REPEAT_PERIOD - 1));
      default: step_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (step_req) begin
          state <= HOLD;
          cnt   <= '0;
          dir   <= up_p;
        end
        HOLD, REPEAT: begin
          if (abort) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (step_req) begin
            state <= REPEAT;
            cnt   <= '0;
          end else if (cnt != CW'(MAXD)) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_comb begin
    step_req = ~mode_p & ~rest_p & (up_p ^ down_p);
    step_up  = up_p;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel     <= '0;
      changed <= 1'b0;
      for (int unsigned k = 0; k < NUM_SETTINGS; k++) regs[k] <= DFLT;
    end else begin
      changed <= 1'b0;
      if (mode_p) begin
        sel <= (sel == LAST) ? '0 : sel + 3'd1;
      end else if (rest_p) begin
        for (int unsigned k = 0; k < NUM_SETTINGS; k++)
          if (sel == 3'(k)) regs[k] <= DFLT;
        changed <= (cur != DFLT);
      end else if (step_req) begin
        for (int unsigned k = 0; k < NUM_SETTINGS; k++)
          if (sel == 3'(k)) regs[k] <= nv;
        changed <= (nv != cur);
      end
    end
  end

endmodule

// File: tb/tb_settings_ctrl.sv
// Directed bench for settings_ctrl; expectations follow SETTINGS_CTRL_AUTOREPEAT_EN.
module tb_settings_ctrl;

`ifdef SETTINGS_CTRL_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  val = '0;
  logic [3:0]  strb = '0;
  logic [2:0]  sel;
  logic [31:0] settings;
  logic        changed;

  int checks = 0;
  int failures = 0;
  int chg_cnt = 0;
  int c0;
  logic [7:0] exp_v;
  logic [7:0] s0_final;

  settings_ctrl #(
    .NUM_SETTINGS (4),
    .WIDTH        (8),
    .DEFAULT_VALUE(128),
    .HOLD_DELAY   (10),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .val     (val),
    .strb    (strb),
    .sel     (sel),
    .settings(settings),
    .changed (changed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (changed === 1'b1) chg_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] s(input int k);
    return settings[k*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int b);
    val[b]  = 1'b1;
    strb[b] = 1'b1;
    tick();
    strb = '0;
  endtask

  task automatic unpress(input int b);
    val[b]  = 1'b0;
    strb[b] = 1'b1;
    tick();
    strb = '0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_sel", 32'(sel), 0);
    check("rst_changed", 32'(changed), 0);
    for (int k = 0; k < 4; k++) check($sformatf("rst_s%0d", k), 32'(s(k)), 32'h80);
    rst = 1'b0;
    tick();

    c0 = chg_cnt;
    for (int i = 1; i <= 4; i++) begin
      press(0);
      check($sformatf("mode_sel%0d", i), 32'(sel), 32'(i % 4));
      check("mode_changed", 32'(changed), 0);
      unpress(0);
    end
    for (int k = 0; k < 4; k++) check($sformatf("mode_s%0d", k), 32'(s(k)), 32'h80);
    check("mode_chg_cnt", 32'(chg_cnt - c0), 0);

    c0 = chg_cnt;
    press(1);
    check("up_s0", 32'(s(0)), 32'h81);
    check("up_changed", 32'(changed), 1);
    tick();
    tick();
    unpress(1);
    check("up_s0_after", 32'(s(0)), 32'h81);
    check("up_chg_cnt", 32'(chg_cnt - c0), 1);

    press(3);
    check("rest0_s0", 32'(s(0)), 32'h80);
    check("rest0_changed", 32'(changed), 1);
    unpress(3);

    c0 = chg_cnt;
    press(1);
    exp_v = 8'h81;
    check("hold_k1", 32'(s(0)), 32'(exp_v));
    for (int k = 2; k <= 30; k++) begin
      tick();
      if (AR && k >= 11 && ((k - 11) % 4) == 0) exp_v = exp_v + 8'd1;
      check($sformatf("hold_k%0d", k), 32'(s(0)), 32'(exp_v));
    end
    unpress(1);
    s0_final = AR ? 8'h86 : 8'h81;
    check("hold_final", 32'(s(0)), 32'(s0_final));
    check("hold_chg_cnt", 32'(chg_cnt - c0), AR ? 6 : 1);

    press(0);
    unpress(0);
    check("sel1", 32'(sel), 1);
    for (int i = 0; i < 127; i++) begin
      press(1);
      unpress(1);
    end
    check("s1_max", 32'(s(1)), 32'hFF);
    press(1);
    check("sat_s1", 32'(s(1)), 32'hFF);
    check("sat_changed", 32'(changed), 0);
    unpress(1);
    press(3);
    check("rest1_s1", 32'(s(1)), 32'h80);
    check("rest1_changed", 32'(changed), 1);
    unpress(3);
    check("s0_untouched", 32'(s(0)), 32'(s0_final));

    val[2:1]  = 2'b11;
    strb[2:1] = 2'b11;
    tick();
    strb = '0;
    check("updn_s1", 32'(s(1)), 32'h80);
    check("updn_changed", 32'(changed), 0);
    tick();
    tick();
    check("updn_s1_late", 32'(s(1)), 32'h80);
    val[2:1]  = 2'b00;
    strb[2:1] = 2'b11;
    tick();
    strb = '0;
    tick();

    press(1);
    for (int k = 2; k <= 14; k++) tick();
    check("pre_rst_s1", 32'(s(1)), AR ? 32'h82 : 32'h81);
    rst = 1'b1;
    #1;
    check("async_rst_sel", 32'(sel), 0);
    check("async_rst_s1", 32'(s(1)), 32'h80);
    check("async_rst_s0", 32'(s(0)), 32'h80);
    check("async_rst_changed", 32'(changed), 0);
    tick();
    tick();
    rst = 1'b0;
    c0 = chg_cnt;
    for (int k = 0; k < 20; k++) tick();
    check("post_rst_s0", 32'(s(0)), 32'h80);
    check("post_rst_sel", 32'(sel), 0);
    check("post_rst_chg_cnt", 32'(chg_cnt - c0), 0);
    unpress(1);
    press(1);
    check("fresh_press_s0", 32'(s(0)), 32'h81);
    unpress(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
